// File: rtl/xadc_drp_pkg.sv
// Shared constants, the XADC init table and the writer FSM state type.
package xadc_drp_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] CFG0 = 7'h40;
    localparam logic [ADDR_W-1:0] CFG1 = 7'h41;
    localparam logic [ADDR_W-1:0] SEQ0 = 7'h48;
    localparam logic [ADDR_W-1:0] SEQ1 = 7'h49;

    localparam int unsigned INIT_LEN = 4;
    localparam int unsigned IDX_W    = $clog2(INIT_LEN);

    // Sequencer mode (CFG1) goes last so the channel selects are in place first.
    localparam logic [ADDR_W-1:0] INIT_ADDR [INIT_LEN] = '{CFG0, SEQ0, SEQ1, CFG1};
    localparam logic [DATA_W-1:0] INIT_DATA [INIT_LEN] = '{16'h0000, 16'h4701, 16'h000C, 16'h2000};

    typedef enum logic [2:0] {
        IDLE,
        INIT_WR,
        USER_WR,
        WAIT_WR,
        RD,
        WAIT_RD,
        NEXT
    } state_t;

endpackage

// File: rtl/xadc_drp_if.sv
// DRP bus between a write master and the XADC primitive.
interface xadc_drp_if;
    import xadc_drp_pkg::*;

    logic [ADDR_W-1:0] DADDR;
    logic              DEN;
    logic              DWE;
    logic [DATA_W-1:0] DI;
    logic [DATA_W-1:0] DO;
    logic              DRDY;

    modport master (output DADDR, DEN, DWE, DI, input DO, DRDY);
    modport slave  (input DADDR, DEN, DWE, DI, output DO, DRDY);

endinterface

// File: rtl/xadc_drp_timeout.sv
// DRDY watchdog: reloads on clear, counts down while run, flags expiry at zero.
module xadc_drp_timeout #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [7:0] LOAD = 8'(TIMEOUT_CYC - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (run && cnt != '0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign expired = run && (cnt == '0);

endmodule

// File: rtl/xadc_drp_writer.sv
// XADC DRP write master: runs the init table after reset/START, then serves
// single user writes, optionally verifying each write by read-back.
module xadc_drp_writer
    import xadc_drp_pkg::*;
#(
    parameter int unsigned NUM_INIT    = 4,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter bit          VERIFY      = 1'b1
) (
    input  logic              DCLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              WR_REQ,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              WR_ACK,
    xadc_drp_if.master        drp,
    output logic              BUSY,
    output logic              INIT_DONE,
    output logic              ERR,
    output logic [ADDR_W-1:0] ERR_ADDR
);

    localparam logic [7:0] LAST = 8'(NUM_INIT - 1);

    state_t            state, state_n;
    logic [7:0]        idx, idx_n;
    logic              src_user;
    logic              boot;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              ld_init, ld_user, fail, ack_n, done_set, clr_status;
    logic              to_run, to_expired;

    always_ff @(posedge DCLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        ld_init    = 1'b0;
        ld_user    = 1'b0;
        fail       = 1'b0;
        ack_n      = 1'b0;
        done_set   = 1'b0;
        clr_status = 1'b0;
        case (state)
            IDLE: begin
                // Reset leaves boot set so init runs without a START pulse;
                // WR_REQ is ignored in the ack cycle so a held request is not re-served.
                if (START || boot) begin
                    state_n    = INIT_WR;
                    idx_n      = '0;
                    ld_init    = 1'b1;
                    clr_status = 1'b1;
                end else if (WR_REQ && !WR_ACK) begin
                    state_n = USER_WR;
                    ld_user = 1'b1;
                end
            end
            INIT_WR, USER_WR: state_n = WAIT_WR;
            WAIT_WR: begin
                if (drp.DRDY) begin
                    if (VERIFY)        state_n = RD;
                    else if (src_user) begin state_n = IDLE; ack_n = 1'b1; end
                    else               state_n = NEXT;
                end else if (to_expired) begin
                    fail    = 1'b1;
                    state_n = IDLE;
                    ack_n   = src_user;
                end
            end
            RD: state_n = WAIT_RD;
            WAIT_RD: begin
                if (drp.DRDY) begin
                    fail = (drp.DO != data_q);
                    if (src_user)  begin state_n = IDLE; ack_n = 1'b1; end
                    else if (fail) state_n = IDLE;
                    else           state_n = NEXT;
                end else if (to_expired) begin
                    fail    = 1'b1;
                    state_n = IDLE;
                    ack_n   = src_user;
                end
            end
            NEXT: begin
                if (idx == LAST) begin
                    done_set = 1'b1;
                    state_n  = IDLE;
                end else begin
                    idx_n   = idx + 8'd1;
                    ld_init = 1'b1;
                    state_n = INIT_WR;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge DCLK or negedge RESET) begin
        if (!RESET) begin
            idx       <= '0;
            boot      <= 1'b1;
            src_user  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            WR_ACK    <= 1'b0;
            INIT_DONE <= 1'b0;
            ERR       <= 1'b0;
            ERR_ADDR  <= '0;
        end else begin
            idx    <= idx_n;
            WR_ACK <= ack_n;
            if (ld_init) begin
                boot     <= 1'b0;
                src_user <= 1'b0;
                addr_q   <= INIT_ADDR[idx_n[IDX_W-1:0]];
                data_q   <= INIT_DATA[idx_n[IDX_W-1:0]];
            end
            if (ld_user) begin
                src_user <= 1'b1;
                addr_q   <= WR_ADDR;
                data_q   <= WR_DATA;
            end
            if (clr_status) begin
                ERR       <= 1'b0;
                ERR_ADDR  <= '0;
                INIT_DONE <= 1'b0;
            end
            if (done_set) INIT_DONE <= 1'b1;
            if (fail) begin
                ERR <= 1'b1;
                if (!ERR) ERR_ADDR <= addr_q;
            end
        end
    end

    assign drp.DEN   = (state == INIT_WR) || (state == USER_WR) || (state == RD);
    assign drp.DWE   = (state == INIT_WR) || (state == USER_WR);
    assign drp.DADDR = addr_q;
    assign drp.DI    = data_q;
    assign BUSY      = (state != IDLE);
    assign to_run    = (state == WAIT_WR) || (state == WAIT_RD);

    xadc_drp_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (DCLK),
        .rst_n   (RESET),
        .clear   (drp.DEN),
        .run     (to_run),
        .expired (to_expired)
    );

endmodule

// File: tb/tb_xadc_drp_writer.sv
// Scoreboard bench for xadc_drp_writer with a behavioural XADC DRP responder.
module tb_xadc_drp_writer;

    logic        DCLK    = 1'b0;
    logic        RESET   = 1'b0;
    logic        START   = 1'b0;
    logic        WR_REQ  = 1'b0;
    logic [6:0]  WR_ADDR = '0;
    logic [15:0] WR_DATA = '0;
    logic        WR_ACK, BUSY, INIT_DONE, ERR;
    logic [6:0]  ERR_ADDR;

    xadc_drp_if drp ();

    xadc_drp_writer #(.NUM_INIT(4), .TIMEOUT_CYC(64), .VERIFY(1'b1)) dut (
        .DCLK      (DCLK),
        .RESET     (RESET),
        .START     (START),
        .WR_REQ    (WR_REQ),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .WR_ACK    (WR_ACK),
        .drp       (drp),
        .BUSY      (BUSY),
        .INIT_DONE (INIT_DONE),
        .ERR       (ERR),
        .ERR_ADDR  (ERR_ADDR)
    );

    always #5 DCLK = ~DCLK;

    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] data;
    } acc_t;

    acc_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0, den_cyc = 0, drdy_cyc = -10, err_cyc = 0, ack_cnt = 0;
    bit          drdy_en = 1'b1, corrupt = 1'b0, pend = 1'b0, prev_err = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] rdata = '0;
    logic [15:0] mem [128];
    logic [6:0]  t_addr [4] = '{7'h40, 7'h48, 7'h49, 7'h41};
    logic [15:0] t_data [4] = '{16'h0000, 16'h4701, 16'h000C, 16'h2000};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_acc(input logic we, input logic [6:0] a, input logic [15:0] d);
        acc_t e;
        e.we = we; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // Write then read-back for each of the first n table entries.
    task automatic push_init(input int n);
        for (int i = 0; i < n; i++) begin
            push_acc(1'b1, t_addr[i], t_data[i]);
            push_acc(1'b0, t_addr[i], 16'h0000);
        end
    endtask

    task automatic serve();
        acc_t e;
        den_cyc = cyc;
        if (exp_q.size() == 0) begin
            check_val("extra_access_addr", 32'(drp.DADDR), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check_val("acc_we", 32'(drp.DWE), 32'(e.we));
            check_val("acc_addr", 32'(drp.DADDR), 32'(e.addr));
            if (e.we) begin
                check_val("acc_di", 32'(drp.DI), 32'(e.data));
                mem[drp.DADDR] = drp.DI;
            end else begin
                check_val("rd_after_drdy", 32'(cyc - drdy_cyc), 32'd1);
            end
        end
        rdata    = (corrupt && drp.DADDR == 7'h48) ? 16'h4700 : mem[drp.DADDR];
        pend     = 1'b1;
        pend_cnt = 3;
    endtask

    // DRP responder and monitor share one process so cycle stamps are consistent.
    initial begin
        drp.DRDY = 1'b0;
        drp.DO   = '0;
        forever begin
            @(negedge DCLK);
            cyc++;
            drp.DRDY = 1'b0;
            if (WR_ACK) ack_cnt++;
            if (ERR && !prev_err) err_cyc = cyc;
            prev_err = ERR;
            if (!RESET) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (pend_cnt == 1) begin
                        pend = 1'b0;
                        if (drdy_en) begin
                            drp.DRDY = 1'b1;
                            drp.DO   = rdata;
                            drdy_cyc = cyc;
                        end
                    end else begin
                        pend_cnt--;
                    end
                end
                if (drp.DWE) check_val("dwe_with_den", 32'(drp.DEN), 32'd1);
                if (drp.DEN) serve();
            end
        end
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge DCLK);
            n++;
        end while (BUSY && n < 3000);
        check_val({tag, "_idle"}, 32'(BUSY), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge DCLK);
        START = 1'b1;
        @(negedge DCLK);
        START = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge DCLK);
        check_val("rst_den", 32'(drp.DEN), 32'd0);
        check_val("rst_dwe", 32'(drp.DWE), 32'd0);
        check_val("rst_daddr", 32'(drp.DADDR), 32'd0);
        check_val("rst_di", 32'(drp.DI), 32'd0);
        check_val("rst_busy", 32'(BUSY), 32'd0);
        check_val("rst_flags", {29'd0, INIT_DONE, ERR, WR_ACK}, 32'd0);
        check_val("rst_err_addr", 32'(ERR_ADDR), 32'd0);

        // Init table runs on reset release with no START.
        push_init(4);
        RESET = 1'b1;
        wait_idle("init");
        check_val("init_done", 32'(INIT_DONE), 32'd1);
        check_val("init_err", 32'(ERR), 32'd0);
        #1 check_val("init_q_empty", 32'(exp_q.size()), 32'd0);

        // Read-back mismatch at 0x48 aborts; a START while busy is ignored.
        corrupt = 1'b1;
        push_init(2);
        pulse_start();
        repeat (3) @(negedge DCLK);
        START = 1'b1;
        @(negedge DCLK);
        START = 1'b0;
        wait_idle("mism");
        check_val("mism_err", 32'(ERR), 32'd1);
        check_val("mism_err_addr", 32'(ERR_ADDR), 32'h48);
        check_val("mism_done", 32'(INIT_DONE), 32'd0);
        repeat (10) @(negedge DCLK);
        #1 check_val("mism_q_empty", 32'(exp_q.size()), 32'd0);
        corrupt = 1'b0;

        // START after an error clears ERR and reruns from entry 0.
        push_init(4);
        pulse_start();
        check_val("restart_err_clr", 32'(ERR), 32'd0);
        check_val("restart_err_addr_clr", 32'(ERR_ADDR), 32'd0);
        check_val("restart_busy", 32'(BUSY), 32'd1);
        wait_idle("rerun");
        check_val("rerun_done", 32'(INIT_DONE), 32'd1);
        check_val("rerun_err", 32'(ERR), 32'd0);

        // User write requested alongside START: served only after the table.
        push_init(4);
        push_acc(1'b1, 7'h49, 16'h0008);
        push_acc(1'b0, 7'h49, 16'h0000);
        #1 ack_cnt = 0;
        @(negedge DCLK);
        START   = 1'b1;
        WR_REQ  = 1'b1;
        WR_ADDR = 7'h49;
        WR_DATA = 16'h0008;
        @(negedge DCLK);
        START = 1'b0;
        n = 0;
        while (!WR_ACK && n < 3000) begin
            @(negedge DCLK);
            n++;
        end
        check_val("user_ack_seen", 32'(WR_ACK), 32'd1);
        check_val("user_after_init", 32'(INIT_DONE), 32'd1);
        @(negedge DCLK);
        WR_REQ = 1'b0;
        repeat (10) @(negedge DCLK);
        #1;
        check_val("user_ack_count", 32'(ack_cnt), 32'd1);
        check_val("user_q_empty", 32'(exp_q.size()), 32'd0);
        check_val("user_mem", 32'(mem[7'h49]), 32'h0008);
        check_val("user_err", 32'(ERR), 32'd0);

        // No DRDY: timeout 64 wait cycles after the write DEN.
        drdy_en = 1'b0;
        push_acc(1'b1, 7'h40, 16'h0000);
        pulse_start();
        wait_idle("tmo");
        #1;
        check_val("tmo_latency", 32'(err_cyc - den_cyc), 32'd65);
        check_val("tmo_err", 32'(ERR), 32'd1);
        check_val("tmo_err_addr", 32'(ERR_ADDR), 32'h40);
        check_val("tmo_done", 32'(INIT_DONE), 32'd0);
        drdy_en = 1'b1;

        // Reset while a user write DEN is high; ERR from the timeout must clear too.
        push_acc(1'b1, 7'h49, 16'h1234);
        @(negedge DCLK);
        WR_REQ  = 1'b1;
        WR_ADDR = 7'h49;
        WR_DATA = 16'h1234;
        n = 0;
        do begin
            @(negedge DCLK);
            n++;
        end while (!drp.DEN && n < 50);
        check_val("rst2_den_seen", 32'(drp.DEN), 32'd1);
        #1;
        RESET  = 1'b0;
        WR_REQ = 1'b0;
        #1;
        check_val("rst2_den", 32'(drp.DEN), 32'd0);
        check_val("rst2_dwe", 32'(drp.DWE), 32'd0);
        check_val("rst2_daddr", 32'(drp.DADDR), 32'd0);
        check_val("rst2_di", 32'(drp.DI), 32'd0);
        check_val("rst2_busy", 32'(BUSY), 32'd0);
        check_val("rst2_err", 32'(ERR), 32'd0);
        check_val("rst2_err_addr", 32'(ERR_ADDR), 32'd0);
        repeat (2) @(negedge DCLK);
        push_init(4);
        RESET = 1'b1;
        wait_idle("reinit");
        check_val("reinit_done", 32'(INIT_DONE), 32'd1);
        #1 check_val("reinit_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/xadc_drp_writer.md
Name: xadc_drp_writer

Overview:
DRP write master for the 7-series XADC primitive, running in the DCLK domain beside the existing XADC measurement reader. After reset it writes a fixed configuration table into the XADC registers: sequencer channel selects, then sequencer mode. It can verify each write by reading the register back. It then accepts single runtime register writes, for example re-selecting the auxiliary channel set, through a request/acknowledge handshake.

Parameters:
NUM_INIT, 4, number of entries in the init table.
TIMEOUT_CYC, 64, DCLK cycles to wait for DRDY before declaring a timeout (range 2..255).
VERIFY, 1, 1 = read back and compare after every write; 0 = write only.

Ports:
DCLK  in  1  DRP clock; all logic on its rising edge.
RESET  in  1  asynchronous, active-low reset.
START  in  1  one-cycle pulse; reruns the init table. Ignored unless in IDLE.
WR_REQ  in  1  level request for one user write; hold until WR_ACK.
WR_ADDR  in  7  user write register address.
WR_DATA  in  16  user write data.
WR_ACK  out  1  one-cycle pulse when the user transaction ends, whether passed or failed.
DADDR  out  7  DRP address.
DEN  out  1  DRP enable; one-cycle pulse per access.
DWE  out  1  DRP write enable; high only together with DEN on writes.
DI  out  16  DRP write data.
DO  in  16  DRP read data.
DRDY  in  1  DRP access complete.
BUSY  out  1  high in every state except IDLE.
INIT_DONE  out  1  high once the whole table completes without error; cleared by START or reset.
ERR  out  1  sticky error flag; cleared by START or reset.
ERR_ADDR  out  7  address of the first failing access.

Behaviour:
- Reset values: every output is 0 (DADDR=0, DI=0, ERR_ADDR=0). After reset the FSM enters INIT_WR at entry 0 with no START needed.
- Default init table, in order: 0x40=0x0000, 0x48=0x4701 (cal, temp, VCCINT, VCCAUX, VCCBRAM), 0x49=0x000C (VAUX2, VAUX3), 0x41=0x2000 (continuous sequencer, written last).
- States: IDLE, INIT_WR, USER_WR, WAIT_WR, RD, WAIT_RD, NEXT.
- Source flag: a flag records whether the current access is an init access or a user access, so the access states are shared.
- INIT_WR and USER_WR:
  - Present DADDR/DI and assert DEN=DWE=1 for exactly one cycle, then go to WAIT_WR.
  - A user access latches WR_ADDR/WR_DATA on entry.
- WAIT_WR, when DRDY is sampled:
  - VERIFY=1: go to RD.
  - VERIFY=0: go to NEXT (init) or IDLE with WR_ACK (user).
- RD: DEN=1, DWE=0 for one cycle at the same address, then WAIT_RD.
- WAIT_RD, when DRDY is sampled: compare DO with the written data.
  - Mismatch: set ERR and ERR_ADDR.
  - Either way, continue as WAIT_WR does for VERIFY=0.
- Timeout:
  - The counter clears on entering WAIT_WR or WAIT_RD.
  - If TIMEOUT_CYC cycles pass without DRDY, set ERR and ERR_ADDR.
  - A user access then ends with WR_ACK.
- Init abort: any error during init aborts the table and goes to IDLE with INIT_DONE=0.
- DRDY on the same cycle the counter expires counts as success.
- DRDY sampled outside WAIT_WR/WAIT_RD is ignored.
- NEXT: increment the entry index. At NUM_INIT, set INIT_DONE and go to IDLE; otherwise go to INIT_WR.
- IDLE priority: START outranks WR_REQ. A WR_REQ that arrives during init is held and served afterwards.
- ERR is sticky: ERR_ADDR keeps the first failure until START or reset clears it.
- Latency, VERIFY=0, WR_REQ high in IDLE at edge k:
  - DEN high in cycle k+1.
  - DRDY sampled at edge m gives WR_ACK in cycle m+1.
- Latency, VERIFY=1: the read DEN follows the write DRDY by exactly one cycle.
- Reset mid-transaction: everything clears at once, DEN drops asynchronously, and init restarts.

Decomposition:
- Package xadc_drp_pkg holds:
  - register address constants (CFG0=0x40, CFG1=0x41, SEQ0=0x48, SEQ1=0x49);
  - the init table as constant arrays of address and data;
  - the FSM state enum;
  - the DRP width constants (7-bit address, 16-bit data).
- One sub-module: xadc_drp_timeout, a loadable down-counter with clear and expire outputs.

Test Plan:
- Reset release, DRP model with 3-cycle DRDY: 4 writes then 4 read-backs interleaved (0x40/0000, 0x48/4701, 0x49/000C, 0x41/2000) -> INIT_DONE=1, ERR=0, BUSY low.
- DRDY never returned -> ERR=1 and ERR_ADDR=0x40 exactly 64 cycles after the wait starts; INIT_DONE=0; IDLE.
- Model returns DO=0x4700 on the 0x48 read-back -> ERR=1, ERR_ADDR=0x48, table aborted, no access to 0x49.
- WR_REQ (0x49, 0x0008) raised during init -> served only after INIT_DONE; one write plus one read; WR_ACK pulses once; the request is not repeated while WR_REQ stays high for a further cycle.
- START while BUSY ignored. START in IDLE after an error -> ERR cleared and the table rerun from entry 0.
- RESET asserted in the cycle DEN is high -> all outputs 0 at once; after release, init restarts at 0x40.
